// File: rtl/coherence_bus_ctrl.sv
// Dual-core coherent bus controller: arbitrates icache/dcache requests onto one RAM port,
// snoops every data read and forwards Modified data cache-to-cache with RAM write-back.
// Ports: CLK/nRST; per-core i/d requests, waits and loads; snoop controls ccwait/ccinv/
// ccsnoopaddr; RAM side ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate.
module coherence_bus_ctrl #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*32-1:0]     iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*32-1:0]     daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  input  logic [CPUS-1:0]        ccwrite,
  input  logic [CPUS-1:0]        cctrans,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] iload,
  output logic [CPUS*WORD_W-1:0] dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*32-1:0]     ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic [2:0] {
    IDLE, WB, SNOOP, C2C, DRD, IRD
  } state_t;

  typedef enum logic [1:0] {
    FREE, BUSY, ACCESS, ERROR
  } ramstate_t;

  state_t        state;
  state_t        arb_nxt;
  logic [GW-1:0] gnt;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] own;
  logic [GW-1:0] arb_idx;
  logic [GW-1:0] own_idx;
  logic [GW-1:0] rr_nxt;
  logic          arb_hit;
  logic          own_hit;
  logic          acc;

  logic [31:0]       g_daddr;
  logic [31:0]       g_iaddr;
  logic [WORD_W-1:0] g_store;
  logic [31:0]       o_daddr;
  logic [WORD_W-1:0] o_store;

  // cctrans is informational only
  logic unused_cctrans;
  assign unused_cctrans = ^cctrans;

  function automatic logic [GW-1:0] rot(
    input logic [GW-1:0] base,
    input int            i
  );
    return GW'((int'(base) + i) % CPUS);
  endfunction

  assign acc     = (ramstate == 2'(ACCESS));
  assign rr_nxt  = rot(gnt, 1);
  assign g_daddr = daddr[int'(gnt)*32 +: 32];
  assign g_iaddr = iaddr[int'(gnt)*32 +: 32];
  assign g_store = dstore[int'(gnt)*WORD_W +: WORD_W];
  assign o_daddr = daddr[int'(own)*32 +: 32];
  assign o_store = dstore[int'(own)*WORD_W +: WORD_W];

  // Later classes override earlier ones, so dWEN > dREN > iREN.
  // Descending scan leaves the core closest at/after rr_ptr.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    arb_nxt = IDLE;
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (iREN[rot(rr_ptr, i)]) begin
        arb_hit = 1'b1;
        arb_idx = rot(rr_ptr, i);
        arb_nxt = IRD;
      end
    end
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (dREN[rot(rr_ptr, i)]) begin
        arb_hit = 1'b1;
        arb_idx = rot(rr_ptr, i);
        arb_nxt = SNOOP;
      end
    end
    for (int i = CPUS - 1; i >= 0; i--) begin
      if (dWEN[rot(rr_ptr, i)]) begin
        arb_hit = 1'b1;
        arb_idx = rot(rr_ptr, i);
        arb_nxt = WB;
      end
    end
  end

  // A snooped core answering with dWEN holds the block Modified.
  always_comb begin
    own_hit = 1'b0;
    own_idx = '0;
    for (int i = CPUS - 1; i >= 1; i--) begin
      if (dWEN[rot(gnt, i)]) begin
        own_hit = 1'b1;
        own_idx = rot(gnt, i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      gnt    <= '0;
      rr_ptr <= '0;
      own    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_hit) begin
            gnt   <= arb_idx;
            state <= arb_nxt;
          end
        end
        SNOOP: begin
          if (own_hit) begin
            own   <= own_idx;
            state <= C2C;
          end else begin
            state <= DRD;
          end
        end
        WB, C2C, DRD, IRD: begin
          if (acc) begin
            state  <= IDLE;
            rr_ptr <= rr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    for (int k = 0; k < CPUS; k++) begin
      iload[k*WORD_W +: WORD_W] = ramload;
      dload[k*WORD_W +: WORD_W] = ramload;
    end
    unique case (state)
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = g_daddr;
        ramstore = g_store;
        if (acc) dwait[gnt] = 1'b0;
      end
      SNOOP: begin
        for (int i = 1; i < CPUS; i++) begin
          ccwait[rot(gnt, i)] = 1'b1;
          ccinv[rot(gnt, i)]  = ccwrite[gnt];
          ccsnoopaddr[int'(rot(gnt, i))*32 +: 32] = g_daddr;
        end
      end
      C2C: begin
        ccwait[own] = 1'b1;
        ccsnoopaddr[int'(own)*32 +: 32] = g_daddr;
        ramWEN   = 1'b1;
        ramaddr  = o_daddr;
        ramstore = o_store;
        dload[int'(gnt)*WORD_W +: WORD_W] = o_store;
        if (acc) begin
          dwait[gnt] = 1'b0;
          dwait[own] = 1'b0;
        end
      end
      DRD: begin
        ramREN  = 1'b1;
        ramaddr = g_daddr;
        if (acc) dwait[gnt] = 1'b0;
      end
      IRD: begin
        ramREN  = 1'b1;
        ramaddr = g_iaddr;
        if (acc) iwait[gnt] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
